// File: rtl/riscv_pipe_pkg.sv
// Shared IF/ID pipeline types: occupancy states, canonical NOP and the entry layout.
package riscv_pipe_pkg;

  localparam int IFID_INST_W = 32;
  localparam int IFID_PC_W   = 64;

  // addi x0, x0, 0
  localparam logic [IFID_INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ifid_state_t;

  typedef struct packed {
    logic [IFID_INST_W-1:0] inst;
    logic [IFID_PC_W-1:0]   pc;
  } ifid_entry_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One load-enabled pipeline entry (data + valid); both update together when load is high.
module pipe_skid_slot #(
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= valid_in;
      data  <= data_in;
    end
  end

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register with 2-entry skid buffer, stall and synchronous flush.
// Optional perf counters (stall_cycles, flush_count) exist only when IFID_PERF_CNT_EN is defined.
//
//   state | meaning
//   EMPTY | no entry held, outputs show NOP
//   ONE   | main slot holds the entry presented to decode
//   TWO   | main and skid slots both full, fetch is back-pressured
module ifid_pipe_reg #(
  parameter int               INST_W   = 32,
  parameter int               PC_W     = 64,
  parameter logic [INST_W-1:0] NOP_INST = riscv_pipe_pkg::NOP_INST
`ifdef IFID_PERF_CNT_EN
  ,
  parameter int               CNT_W    = 32
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_instruction,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_instruction,
  output logic [PC_W-1:0]   out_pc
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
`endif
);
  import riscv_pipe_pkg::*;

  localparam int ENT_W = INST_W + PC_W;

  ifid_state_t      state, state_nxt;
  logic             accept, deliver;
  logic [ENT_W-1:0] in_data;
  logic             main_ld, main_vin, main_valid;
  logic [ENT_W-1:0] main_din, main_q;
  logic             skid_ld, skid_vin, skid_valid;
  logic [ENT_W-1:0] skid_q;

  assign in_data  = {in_instruction, in_pc};
  assign in_ready = (state != TWO);
  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    main_ld   = 1'b0;
    main_vin  = 1'b0;
    main_din  = in_data;
    skid_ld   = 1'b0;
    skid_vin  = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = ONE;
          main_ld   = 1'b1;
          main_vin  = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          main_ld  = 1'b1;
          main_vin = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          skid_ld   = 1'b1;
          skid_vin  = 1'b1;
        end else if (deliver) begin
          state_nxt = EMPTY;
          main_ld   = 1'b1;
        end
      end
      TWO: begin
        // skid entry moves forward; keeps FIFO order
        if (deliver) begin
          state_nxt = ONE;
          main_ld   = 1'b1;
          main_vin  = skid_valid;
          main_din  = skid_q;
          skid_ld   = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flush wins over any accept or deliver at the same edge.
    if (flush) begin
      state_nxt = EMPTY;
      main_ld   = 1'b1;
      main_vin  = 1'b0;
      skid_ld   = 1'b1;
      skid_vin  = 1'b0;
    end
  end

  pipe_skid_slot #(.DATA_W(ENT_W)) u_main (
    .clk      (clk),
    .reset    (reset),
    .load     (main_ld),
    .valid_in (main_vin),
    .data_in  (main_din),
    .valid    (main_valid),
    .data     (main_q)
  );

  pipe_skid_slot #(.DATA_W(ENT_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .load     (skid_ld),
    .valid_in (skid_vin),
    .data_in  (in_data),
    .valid    (skid_valid),
    .data     (skid_q)
  );

  assign out_valid       = main_valid;
  assign out_instruction = main_valid ? main_q[ENT_W-1:PC_W] : NOP_INST;
  assign out_pc          = main_valid ? main_q[PC_W-1:0]     : '0;

`ifdef IFID_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_ONE;
      if (flush && (state != EMPTY) && (flush_count != '1))
        flush_count <= flush_count + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Directed self-checking bench for ifid_pipe_reg; perf checks only when IFID_PERF_CNT_EN is defined.
module tb_ifid_pipe_reg;
  import riscv_pipe_pkg::*;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instruction;
  logic [63:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int n_chk;
  int n_fail;

  ifid_pipe_reg dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc)
`ifdef IFID_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input ifid_entry_t e);
    in_valid       = v;
    in_instruction = e.inst;
    in_pc          = e.pc;
  endtask

  task automatic chk_out(input string tag, input logic v, input ifid_entry_t e);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_inst"},  64'(out_instruction), 64'(v ? e.inst : 32'h0000_0013));
    chk({tag, "_pc"},    out_pc, v ? e.pc : 64'h0);
  endtask

  ifid_entry_t ea, eb, ec, ed, ee, ef, eg, eh, ej, ez;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    ea = '{inst: 32'h0050_0093, pc: 64'h0};
    eb = '{inst: 32'h00A0_0113, pc: 64'h4};
    ec = '{inst: 32'h0010_0193, pc: 64'h8};
    ed = '{inst: 32'h0020_0213, pc: 64'hC};
    ee = '{inst: 32'h0030_0293, pc: 64'h10};
    ef = '{inst: 32'h0040_0313, pc: 64'h20};
    eg = '{inst: 32'h0050_0393, pc: 64'h24};
    eh = '{inst: 32'h0060_0413, pc: 64'h28};
    ej = '{inst: 32'h0070_0493, pc: 64'h100};
    ez = '{inst: 32'h0, pc: 64'h0};

    // reset held low while fetch offers an instruction
    reset     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, '{inst: 32'hDEAD_BEEF, pc: 64'h40});
    tick();
    tick();
    chk_out("rst", 1'b0, ez);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef IFID_PERF_CNT_EN
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_flush", 64'(flush_count), 64'd0);
`endif
    drive(1'b0, ez);
    reset = 1'b1;
    tick();
    chk_out("idle", 1'b0, ez);

    // streaming, back-to-back with decode always ready
    drive(1'b1, ea);
    tick();
    chk_out("str_a", 1'b1, ea);
    drive(1'b1, eb);
    tick();
    chk_out("str_b", 1'b1, eb);
    chk("str_b_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, ez);
    tick();
    chk_out("str_drain", 1'b0, ez);

    // stall: three offered, two accepted
    out_ready = 1'b0;
    drive(1'b1, ec);
    tick();
    chk("stl_rdy1", 64'(in_ready), 64'd1);
    chk_out("stl_c", 1'b1, ec);
    drive(1'b1, ed);
    tick();
    chk("stl_rdy2", 64'(in_ready), 64'd0);
    chk_out("stl_c2", 1'b1, ec);
    drive(1'b1, ee);
    tick();
    chk("stl_rdy3", 64'(in_ready), 64'd0);
    chk_out("stl_c3", 1'b1, ec);
    drive(1'b0, ez);
    out_ready = 1'b1;
    tick();
    chk_out("stl_d", 1'b1, ed);
    chk("stl_rdy4", 64'(in_ready), 64'd1);
    tick();
    chk_out("stl_empty", 1'b0, ez);

    // flush from TWO with a simultaneous valid input
    out_ready = 1'b0;
    drive(1'b1, ef);
    tick();
    drive(1'b1, eg);
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    drive(1'b1, eh);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, ez);
    chk_out("fl", 1'b0, ez);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick();
    chk_out("fl_after", 1'b0, ez);

    // async reset in the middle of a cycle with an entry held
    out_ready = 1'b0;
    drive(1'b1, ea);
    tick();
    drive(1'b0, ez);
    chk_out("ar_pre", 1'b1, ea);
    #2;
    reset = 1'b0;
    #1;
    chk_out("ar", 1'b0, ez);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
`ifdef IFID_PERF_CNT_EN
    chk("ar_stall", 64'(stall_cycles), 64'd0);
`endif
    #1;
    reset = 1'b1;
    tick();

`ifdef IFID_PERF_CNT_EN
    // five stalled cycles, then flush of one held entry, then flush while empty
    out_ready = 1'b0;
    drive(1'b1, ej);
    tick();
    drive(1'b0, ez);
    for (int i = 0; i < 5; i++) tick();
    chk("pf_stall5", 64'(stall_cycles), 64'd5);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("pf_flush1", 64'(flush_count), 64'd1);
    tick();
    flush = 1'b0;
    chk("pf_flush_empty", 64'(flush_count), 64'd1);
    chk("pf_stall_end", 64'(stall_cycles), 64'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
